// File: rtl/tape_pulse_decoder.sv
// Tape EAR pulse decoder: measures half-pulse widths in microseconds, detects the
// pilot tone and sync pulse, then assembles MSB-first bytes from full-period widths.
module tape_pulse_decoder #(
  parameter int unsigned CLK_FREQ    = 27000000,
  parameter int unsigned PILOT_MIN   = 256,
  parameter int unsigned T_PILOT_LO  = 500,
  parameter int unsigned T_PILOT_HI  = 800,
  parameter int unsigned T_BIT_SPLIT = 732,
  parameter int unsigned T_PER_MIN   = 300,
  parameter int unsigned T_PER_MAX   = 1300,
  parameter int unsigned T_TIMEOUT   = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ear,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        block_start,
  output logic        block_end,
  output logic        err,
  output logic [15:0] byte_count,
  output logic        active
);

  localparam int unsigned Div  = (CLK_FREQ / 1000000 > 0) ? CLK_FREQ / 1000000 : 1;
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;

  localparam logic [11:0] PilotLo  = 12'(T_PILOT_LO);
  localparam logic [11:0] PilotHi  = 12'(T_PILOT_HI);
  localparam logic [11:0] Timeout  = 12'(T_TIMEOUT);
  localparam logic [12:0] BitSplit = 13'(T_BIT_SPLIT);
  localparam logic [12:0] PerMin   = 13'(T_PER_MIN);
  localparam logic [12:0] PerMax   = 13'(T_PER_MAX);
  localparam logic [15:0] PilotMin = 16'(PILOT_MIN);

  typedef enum logic [2:0] {StIdle, StPilot, StSync2, StDataH1, StDataH2} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q;
  logic            tick;
  logic            sync1_q, sync2_q, prev_q;
  logic            ear_edge;
  logic [11:0]     w_q;
  logic [15:0]     pilot_cnt_q, pilot_cnt_d;
  logic [11:0]     h1_q, h1_d;
  logic [6:0]      shreg_q, shreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic [15:0]     byte_count_q, byte_count_d;
  logic            dv_q, dv_d, bs_q, bs_d, be_q, be_d, err_q, err_d;
  logic            pilot_in;
  logic [12:0]     period;
  logic            period_ok;
  logic            bit_val;
  logic            timeout;
  logic            data_to;

  assign tick     = (pre_q == PreW'(Div - 1));
  assign ear_edge = sync2_q ^ prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      w_q     <= '0;
    end else begin
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      sync1_q <= ear;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // The FSM consumes w_q as the half-pulse width in the same cycle it is cleared.
      if (ear_edge) begin
        w_q <= '0;
      end else if (tick && (w_q != 12'hFFF)) begin
        w_q <= w_q + 12'd1;
      end
    end
  end

  assign pilot_in  = (w_q >= PilotLo) && (w_q <= PilotHi);
  assign period    = {1'b0, h1_q} + {1'b0, w_q};
  assign period_ok = (period >= PerMin) && (period <= PerMax);
  assign bit_val   = (period >= BitSplit);
  assign timeout   = (w_q >= Timeout);

  always_comb begin
    state_d      = state_q;
    pilot_cnt_d  = pilot_cnt_q;
    h1_d         = h1_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    byte_count_d = byte_count_q;
    dv_d         = 1'b0;
    bs_d         = 1'b0;
    be_d         = 1'b0;
    err_d        = 1'b0;
    data_to      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ear_edge && pilot_in) begin
          state_d     = StPilot;
          pilot_cnt_d = 16'd1;
        end
      end
      StPilot: begin
        if (ear_edge) begin
          if (pilot_in) begin
            if (pilot_cnt_q != 16'hFFFF) pilot_cnt_d = pilot_cnt_q + 16'd1;
          end else if ((w_q < PilotLo) && (pilot_cnt_q >= PilotMin)) begin
            state_d      = StSync2;
            bs_d         = 1'b1;
            byte_count_d = '0;
            bit_cnt_d    = '0;
            shreg_d      = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StSync2: begin
        if (ear_edge) begin
          state_d = StDataH1;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDataH1: begin
        if (ear_edge) begin
          h1_d    = w_q;
          state_d = StDataH2;
        end else begin
          data_to = timeout;
        end
      end
      StDataH2: begin
        if (ear_edge) begin
          state_d = StDataH1;
          if (!period_ok) begin
            state_d   = StIdle;
            err_d     = 1'b1;
            shreg_d   = '0;
            bit_cnt_d = '0;
          end else begin
            shreg_d = {shreg_q[5:0], bit_val};
            if (bit_cnt_q == 3'd7) begin
              data_d    = {shreg_q, bit_val};
              dv_d      = 1'b1;
              bit_cnt_d = '0;
              if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end else begin
          data_to = timeout;
        end
      end
      default: state_d = StIdle;
    endcase

    // A block ending mid-byte drops the partial byte and flags it.
    if (data_to) begin
      state_d   = StIdle;
      be_d      = 1'b1;
      err_d     = (bit_cnt_q != 3'd0);
      shreg_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pilot_cnt_q  <= '0;
      h1_q         <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      byte_count_q <= '0;
      dv_q         <= 1'b0;
      bs_q         <= 1'b0;
      be_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pilot_cnt_q  <= pilot_cnt_d;
      h1_q         <= h1_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      byte_count_q <= byte_count_d;
      dv_q         <= dv_d;
      bs_q         <= bs_d;
      be_q         <= be_d;
      err_q        <= err_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign block_start = bs_q;
  assign block_end   = be_q;
  assign err         = err_q;
  assign byte_count  = byte_count_q;
  assign active      = (state_q != StIdle);

endmodule

// File: tb/tb_tape_pulse_decoder.sv
// Directed bench for tape_pulse_decoder with timing parameters scaled down by 10 and a
// 2 MHz clock so whole blocks fit in a short run.
module tb_tape_pulse_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ear;
  logic [7:0]  data;
  logic        data_valid, block_start, block_end, err, active;
  logic [15:0] byte_count;

  tape_pulse_decoder #(
    .CLK_FREQ   (2000000),
    .PILOT_MIN  (16),
    .T_PILOT_LO (50),
    .T_PILOT_HI (80),
    .T_BIT_SPLIT(73),
    .T_PER_MIN  (30),
    .T_PER_MAX  (130),
    .T_TIMEOUT  (200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ear        (ear),
    .data       (data),
    .data_valid (data_valid),
    .block_start(block_start),
    .block_end  (block_end),
    .err        (err),
    .byte_count (byte_count),
    .active     (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe monitor
  int n_dv = 0, n_bs = 0, n_be = 0, n_err = 0, n_be_err = 0, n_coinc = 0, n_long = 0;
  logic [7:0] last_data = 8'h00;
  logic p_dv = 1'b0, p_bs = 1'b0, p_be = 1'b0, p_err = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      n_dv++;
      last_data = data;
    end
    if (block_start) n_bs++;
    if (block_end) n_be++;
    if (err) n_err++;
    if (block_end && err) n_be_err++;
    if (block_end && data_valid) n_coinc++;
    if ((data_valid && p_dv) || (block_start && p_bs) || (block_end && p_be) || (err && p_err))
      n_long++;
    p_dv  = data_valid;
    p_bs  = block_start;
    p_be  = block_end;
    p_err = err;
  end

  int b_dv, b_bs, b_be, b_err, b_be_err;

  task automatic snap();
    b_dv     = n_dv;
    b_bs     = n_bs;
    b_be     = n_be;
    b_err    = n_err;
    b_be_err = n_be_err;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One half-pulse of the given width in microseconds, ended by an ear transition.
  task automatic half(input int us);
    repeat (us * 2) @(posedge clk);
    #1 ear = ~ear;
  endtask

  task automatic idle_us(input int us);
    repeat (us * 2) @(posedge clk);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pilot(input int n);
    for (int i = 0; i < n; i++) half(62);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      half(49);
      half(49);
    end else begin
      half(24);
      half(24);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"}, 32'(data), 32'h00);
    check({tag, "_byte_count"}, 32'(byte_count), 32'h0);
    check({tag, "_strobes"}, {28'h0, data_valid, block_start, block_end, err}, 32'h0);
    check({tag, "_active"}, 32'(active), 32'h0);
  endtask

  initial begin
    ear   = 1'b1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Scenario 1: pilot then sync, exact block_start timing
    snap();
    pilot(20);
    wait_neg(2);
    check("s1_active_in_pilot", 32'(active), 32'h1);
    half(19);
    wait_neg(3);
    check("s1_bs_before", 32'(block_start), 32'h0);
    wait_neg(1);
    check("s1_bs_strobe", 32'(block_start), 32'h1);
    check("s1_active", 32'(active), 32'h1);
    wait_neg(1);
    check("s1_bs_single", 32'(block_start), 32'h0);
    half(21);

    // Scenario 2: byte 0xA5 then idle timeout
    send_byte(8'hA5);
    wait_neg(10);
    check("s2_dv_count", 32'(n_dv - b_dv), 32'd1);
    check("s2_data", 32'(data), 32'hA5);
    check("s2_last_data", 32'(last_data), 32'hA5);
    check("s2_byte_count", 32'(byte_count), 32'd1);
    idle_us(300);
    @(negedge clk);
    check("s2_block_end", 32'(n_be - b_be), 32'd1);
    check("s2_no_err", 32'(n_err - b_err), 32'd0);
    check("s2_idle", 32'(active), 32'h0);

    // Scenario 3: short pilot, sync ignored
    snap();
    pilot(6);
    wait_neg(5);
    check("s3_active_in_pilot", 32'(active), 32'h1);
    half(19);
    half(21);
    wait_neg(10);
    check("s3_no_bs", 32'(n_bs - b_bs), 32'd0);
    check("s3_idle", 32'(active), 32'h0);
    idle_us(300);

    // Scenario 4: three bits then an over-long period
    snap();
    pilot(20);
    half(19);
    half(21);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    half(75);
    half(75);
    wait_neg(10);
    check("s4_bs", 32'(n_bs - b_bs), 32'd1);
    check("s4_err", 32'(n_err - b_err), 32'd1);
    check("s4_idle", 32'(active), 32'h0);
    check("s4_byte_count", 32'(byte_count), 32'd0);
    check("s4_no_dv", 32'(n_dv - b_dv), 32'd0);
    idle_us(300);
    @(negedge clk);
    check("s4_no_block_end", 32'(n_be - b_be), 32'd0);

    // Scenario 5: 0x00, 0xFF, five bits, then timeout
    snap();
    pilot(20);
    half(19);
    half(21);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    idle_us(300);
    @(negedge clk);
    check("s5_dv_count", 32'(n_dv - b_dv), 32'd2);
    check("s5_last_data", 32'(last_data), 32'hFF);
    check("s5_byte_count", 32'(byte_count), 32'd2);
    check("s5_block_end", 32'(n_be - b_be), 32'd1);
    check("s5_err", 32'(n_err - b_err), 32'd1);
    check("s5_be_err_same_cycle", 32'(n_be_err - b_be_err), 32'd1);
    check("s5_idle", 32'(active), 32'h0);

    // Scenario 6: one-cycle reset mid-byte, then a clean block
    pilot(20);
    half(19);
    half(21);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_neg(10);
    snap();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("s6_reset");
    idle_us(300);
    check("s6_no_be", 32'(n_be - b_be), 32'd0);
    check("s6_no_err", 32'(n_err - b_err), 32'd0);
    check("s6_no_dv", 32'(n_dv - b_dv), 32'd0);
    snap();
    pilot(20);
    half(19);
    half(21);
    send_byte(8'h3C);
    wait_neg(10);
    check("s6_data", 32'(data), 32'h3C);
    check("s6_byte_count", 32'(byte_count), 32'd1);
    idle_us(300);
    @(negedge clk);
    check("s6_bs", 32'(n_bs - b_bs), 32'd1);
    check("s6_dv", 32'(n_dv - b_dv), 32'd1);
    check("s6_be", 32'(n_be - b_be), 32'd1);
    check("s6_err", 32'(n_err - b_err), 32'd0);

    check("strobe_single_cycle", 32'(n_long), 32'd0);
    check("be_dv_disjoint", 32'(n_coinc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
